// File: rtl/clock_pkg.sv
// Shared state codes, field-select codes and field limits for the
// front-panel time/alarm editing logic.
package clock_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_EDIT_HOUR = 3'd1;
  localparam state_t ST_EDIT_MIN  = 3'd2;
  localparam state_t ST_EDIT_SEC  = 3'd3;
  localparam state_t ST_COMMIT    = 3'd4;

  typedef logic [1:0] field_t;
  localparam field_t FIELD_NONE = 2'd0;
  localparam field_t FIELD_HOUR = 2'd1;
  localparam field_t FIELD_MIN  = 2'd2;
  localparam field_t FIELD_SEC  = 2'd3;

  localparam logic [7:0] MAX_HOUR   = 8'd23;
  localparam logic [7:0] MAX_MINSEC = 8'd59;

  function automatic logic is_edit_state(input state_t s);
    return (s == ST_EDIT_HOUR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
  endfunction

endpackage

// File: rtl/wrap_counter_field.sv
// One editable time field: modulo-(MAX+1) up/down stepping, with a load
// that replaces any out-of-range value by zero.
module wrap_counter_field
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = MAX_MINSEC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step_up,
  input  logic       step_dn,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 8'd0;
    end else if (load) begin
      value <= (load_val > MAX) ? 8'd0 : load_val;
    end else if (step_up) begin
      value <= (value >= MAX) ? 8'd0 : value + 8'd1;
    end else if (step_dn) begin
      value <= (value == 8'd0) ? MAX : value - 8'd1;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Front-panel edit controller: turns button levels into an hour/min/sec edit
// session that ends in a one-cycle set_time or set_alarm commit strobe.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int REPEAT_DELAY   = 2,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  input  logic       target_sel,
  input  logic [7:0] cur_sec,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_hour,
  output logic       set_time,
  output logic       set_alarm,
  output logic [7:0] out_sec,
  output logic [7:0] out_min,
  output logic [7:0] out_hour,
  output logic       edit_active,
  output logic [1:0] edit_field,
  output logic       edit_target
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_DELAY - 1);

  state_t     state, state_nxt;
  logic [4:0] btn_now, btn_prev, btn_edge;
  logic       mode_edge, inc_edge, dec_edge, confirm_edge, cancel_edge;
  logic [CNT_W-1:0] rpt_cnt, idle_cnt;
  logic       rpt_ok, inc_evt, dec_evt, step_up, step_dn;
  logic       activity, timed_out, in_edit;
  logic       load, do_commit;
  logic       hour_up, hour_dn, min_up, min_dn, sec_up, sec_dn;
  logic [7:0] edit_hour, edit_min, edit_sec;
  logic [7:0] shadow_hour, shadow_min, shadow_sec;
  logic [7:0] load_hour, load_min, load_sec;

  assign btn_now  = {btn_cancel, btn_confirm, btn_mode, btn_inc, btn_dec};
  assign btn_edge = btn_now & ~btn_prev;
  assign {cancel_edge, confirm_edge, mode_edge, inc_edge, dec_edge} = btn_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_prev <= 5'd0;
    else       btn_prev <= btn_now;
  end

  // Held cycles since the last inc/dec press; saturates so long holds keep repeating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (inc_edge || dec_edge) begin
      rpt_cnt <= '0;
    end else if (btn_inc || btn_dec) begin
      if (rpt_cnt != '1) rpt_cnt <= rpt_cnt + CNT_W'(1);
    end else begin
      rpt_cnt <= '0;
    end
  end

  assign rpt_ok    = !(inc_edge || dec_edge) && (rpt_cnt >= REPEAT_LAST);
  assign inc_evt   = inc_edge || (btn_inc && rpt_ok);
  assign dec_evt   = dec_edge || (btn_dec && rpt_ok);
  assign step_up   = inc_evt && !dec_evt;
  assign step_dn   = dec_evt && !inc_evt;
  assign activity  = (|btn_edge) || ((btn_inc || btn_dec) && rpt_ok);
  assign in_edit   = is_edit_state(state);
  assign timed_out = in_edit && !activity && (idle_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               idle_cnt <= '0;
    else if (!in_edit || activity || timed_out) idle_cnt <= '0;
    else                                     idle_cnt <= idle_cnt + CNT_W'(1);
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    do_commit = 1'b0;
    hour_up   = 1'b0;
    hour_dn   = 1'b0;
    min_up    = 1'b0;
    min_dn    = 1'b0;
    sec_up    = 1'b0;
    sec_dn    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode_edge) begin
          load      = 1'b1;
          state_nxt = ST_EDIT_HOUR;
        end
      end
      ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC: begin
        if (cancel_edge) begin
          state_nxt = ST_IDLE;
        end else if (confirm_edge) begin
          do_commit = 1'b1;
          state_nxt = ST_COMMIT;
        end else if (mode_edge) begin
          if (state == ST_EDIT_HOUR)     state_nxt = ST_EDIT_MIN;
          else if (state == ST_EDIT_MIN) state_nxt = ST_EDIT_SEC;
          else                           state_nxt = ST_EDIT_HOUR;
        end else if (timed_out) begin
          state_nxt = ST_IDLE;
        end else begin
          hour_up = (state == ST_EDIT_HOUR) && step_up;
          hour_dn = (state == ST_EDIT_HOUR) && step_dn;
          min_up  = (state == ST_EDIT_MIN)  && step_up;
          min_dn  = (state == ST_EDIT_MIN)  && step_dn;
          sec_up  = (state == ST_EDIT_SEC)  && step_up;
          sec_dn  = (state == ST_EDIT_SEC)  && step_dn;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      edit_target <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) edit_target <= target_sel;
    end
  end

  // Outputs and the alarm shadow load on the confirm edge so they are valid with the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_hour    <= 8'd0;
      out_min     <= 8'd0;
      out_sec     <= 8'd0;
      shadow_hour <= 8'd0;
      shadow_min  <= 8'd0;
      shadow_sec  <= 8'd0;
    end else if (do_commit) begin
      out_hour <= edit_hour;
      out_min  <= edit_min;
      out_sec  <= edit_sec;
      if (edit_target) begin
        shadow_hour <= edit_hour;
        shadow_min  <= edit_min;
        shadow_sec  <= edit_sec;
      end
    end
  end

  assign load_hour = target_sel ? shadow_hour : cur_hour;
  assign load_min  = target_sel ? shadow_min  : cur_min;
  assign load_sec  = target_sel ? shadow_sec  : cur_sec;

  wrap_counter_field #(.MAX(MAX_HOUR)) u_hour (
    .clk(clk), .reset(reset), .load(load), .load_val(load_hour),
    .step_up(hour_up), .step_dn(hour_dn), .value(edit_hour)
  );

  wrap_counter_field #(.MAX(MAX_MINSEC)) u_min (
    .clk(clk), .reset(reset), .load(load), .load_val(load_min),
    .step_up(min_up), .step_dn(min_dn), .value(edit_min)
  );

  wrap_counter_field #(.MAX(MAX_MINSEC)) u_sec (
    .clk(clk), .reset(reset), .load(load), .load_val(load_sec),
    .step_up(sec_up), .step_dn(sec_dn), .value(edit_sec)
  );

  assign set_time    = (state == ST_COMMIT) && !edit_target;
  assign set_alarm   = (state == ST_COMMIT) && edit_target;
  assign edit_active = in_edit;

  always_comb begin
    edit_field = FIELD_NONE;
    case (state)
      ST_EDIT_HOUR: edit_field = FIELD_HOUR;
      ST_EDIT_MIN:  edit_field = FIELD_MIN;
      ST_EDIT_SEC:  edit_field = FIELD_SEC;
      default:      edit_field = FIELD_NONE;
    endcase
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random
// button traffic compared every cycle against a behavioural session model.
module tb_time_set_controller;

  localparam int TIMEOUT_CYCLES = 30;
  localparam int REPEAT_DELAY   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec, btn_confirm, btn_cancel, target_sel;
  logic [7:0] cur_sec, cur_min, cur_hour;
  logic       set_time, set_alarm;
  logic [7:0] out_sec, out_min, out_hour;
  logic       edit_active;
  logic [1:0] edit_field;
  logic       edit_target;

  int checks = 0;
  int errors = 0;
  int time_strobes = 0;
  int alarm_strobes = 0;

  // Behavioural model of the edit session
  bit m_edit, m_commit, m_target;
  int m_field;
  int m_val[3];
  int m_shadow[3];
  int m_out[3];
  int m_held, m_quiet;
  bit p_mode, p_inc, p_dec, p_conf, p_cancel;

  time_set_controller #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_confirm(btn_confirm), .btn_cancel(btn_cancel), .target_sel(target_sel),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .set_time(set_time), .set_alarm(set_alarm),
    .out_sec(out_sec), .out_min(out_min), .out_hour(out_hour),
    .edit_active(edit_active), .edit_field(edit_field), .edit_target(edit_target)
  );

  always #5 clk = ~clk;

  function automatic int lim(input int k);
    return (k == 0) ? 23 : 59;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_edit = 0; m_commit = 0; m_target = 0; m_field = 0;
    m_held = 0; m_quiet = 0;
    p_mode = 0; p_inc = 0; p_dec = 0; p_conf = 0; p_cancel = 0;
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_shadow[k] = 0; m_out[k] = 0;
    end
  endtask

  task automatic modelStep();
    bit e_mode, e_inc, e_dec, e_conf, e_cancel, rep, inc_ev, dec_ev, active;
    int cur[3];
    int src;
    e_mode   = btn_mode && !p_mode;
    e_inc    = btn_inc && !p_inc;
    e_dec    = btn_dec && !p_dec;
    e_conf   = btn_confirm && !p_conf;
    e_cancel = btn_cancel && !p_cancel;
    if (e_inc || e_dec)            m_held = 0;
    else if (btn_inc || btn_dec)   m_held++;
    else                           m_held = 0;
    rep    = !(e_inc || e_dec) && (btn_inc || btn_dec) && (m_held >= REPEAT_DELAY);
    inc_ev = e_inc || (rep && btn_inc);
    dec_ev = e_dec || (rep && btn_dec);
    active = e_mode || e_inc || e_dec || e_conf || e_cancel || rep;
    cur[0] = int'(cur_hour); cur[1] = int'(cur_min); cur[2] = int'(cur_sec);
    if (m_commit) begin
      m_commit = 0;
    end else if (!m_edit) begin
      if (e_mode) begin
        m_target = target_sel;
        for (int k = 0; k < 3; k++) begin
          src = target_sel ? m_shadow[k] : cur[k];
          m_val[k] = (src > lim(k)) ? 0 : src;
        end
        m_edit = 1; m_field = 0; m_quiet = 0;
      end
    end else begin
      if (e_cancel) m_edit = 0;
      else if (e_conf) begin
        m_edit = 0; m_commit = 1;
        m_out = m_val;
        if (m_target) m_shadow = m_val;
      end
      else if (e_mode) m_field = (m_field + 1) % 3;
      else if (!active && (m_quiet + 1 == TIMEOUT_CYCLES)) m_edit = 0;
      else if (inc_ev && !dec_ev) m_val[m_field] = (m_val[m_field] + 1) % (lim(m_field) + 1);
      else if (dec_ev && !inc_ev) m_val[m_field] = (m_val[m_field] + lim(m_field)) % (lim(m_field) + 1);
      m_quiet = active ? 0 : m_quiet + 1;
    end
    p_mode = btn_mode; p_inc = btn_inc; p_dec = btn_dec; p_conf = btn_confirm; p_cancel = btn_cancel;
  endtask

  task automatic compareModel();
    checkOutput("strobes", {set_time, set_alarm}, {m_commit && !m_target, m_commit && m_target});
    checkOutput("out_hms", {out_hour, out_min, out_sec}, {8'(m_out[0]), 8'(m_out[1]), 8'(m_out[2])});
    checkOutput("status", {edit_active, edit_field, edit_target},
                {m_edit, (m_edit ? 2'(m_field + 1) : 2'd0), m_target});
  endtask

  task automatic applyStimulus(input bit m, input bit i, input bit d, input bit cf, input bit cn);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_confirm = cf; btn_cancel = cn;
    @(posedge clk);
    modelStep();
    #1;
    if (set_time)  time_strobes++;
    if (set_alarm) alarm_strobes++;
    compareModel();
  endtask

  task automatic press(input bit m, input bit i, input bit d, input bit cf, input bit cn);
    applyStimulus(m, i, d, cf, cn);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_confirm = 0; btn_cancel = 0;
    #3 reset = 1'b1;
    #1;
    checkOutput("reset_outputs",
                {set_time, set_alarm, out_hour, out_min, out_sec, edit_active, edit_field, edit_target}, 32'd0);
    modelReset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic setCur(input int h, input int mi, input int s);
    cur_hour = 8'(h); cur_min = 8'(mi); cur_sec = 8'(s);
  endtask

  initial begin
    int s0, a0;
    bit r_mode, r_inc, r_dec, r_conf, r_cancel;
    reset = 1'b1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_confirm = 0; btn_cancel = 0;
    target_sel = 0;
    setCur(0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state",
                {set_time, set_alarm, out_hour, out_min, out_sec, edit_active, edit_field, edit_target}, 32'd0);
    #1 reset = 1'b0;
    idle(2);

    // Time edit with decrement wrap 10 -> 23
    setCur(10, 20, 30); target_sel = 0;
    s0 = time_strobes; a0 = alarm_strobes;
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) press(0, 0, 1, 0, 0);
    press(0, 0, 0, 1, 0);
    checkOutput("t1_out", {out_hour, out_min, out_sec}, {8'd23, 8'd20, 8'd30});
    checkOutput("t1_time_pulses", 32'(time_strobes - s0), 32'd1);
    checkOutput("t1_alarm_pulses", 32'(alarm_strobes - a0), 32'd0);

    // Alarm edit from the cleared shadow
    target_sel = 1;
    s0 = time_strobes; a0 = alarm_strobes;
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checkOutput("t2_out", {out_hour, out_min, out_sec}, {8'd0, 8'd1, 8'd4});
    checkOutput("t2_alarm_pulses", 32'(alarm_strobes - a0), 32'd1);
    checkOutput("t2_time_pulses", 32'(time_strobes - s0), 32'd0);
    // Second alarm session starts from the shadow; target_sel is only sampled at entry
    press(1, 0, 0, 0, 0);
    target_sel = 0;
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checkOutput("t2_second_out", {out_hour, out_min, out_sec}, {8'd1, 8'd1, 8'd4});
    checkOutput("t2_second_pulses", 32'(alarm_strobes - a0), 32'd2);

    // Minute auto-repeat across the 59 wrap
    setCur(0, 58, 0); target_sel = 0;
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checkOutput("t3_out", {out_hour, out_min, out_sec}, {8'd0, 8'd1, 8'd0});

    // Cancel leaves outputs untouched
    s0 = time_strobes; a0 = alarm_strobes;
    press(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) press(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t4_inactive", edit_active, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_out", {out_hour, out_min, out_sec}, {8'd0, 8'd1, 8'd0});
    checkOutput("t4_no_pulse", 32'(time_strobes - s0 + alarm_strobes - a0), 32'd0);

    // Confirm and cancel together, then timeout
    press(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("t5_both_inactive", edit_active, 1'b0);
    idle(3);
    press(1, 0, 0, 0, 0);
    idle(28);
    checkOutput("t5_still_active", edit_active, 1'b1);
    idle(1);
    checkOutput("t5_timed_out", edit_active, 1'b0);
    checkOutput("t5_no_pulse", 32'(time_strobes - s0 + alarm_strobes - a0), 32'd0);

    // Async reset mid-session, then sanitised snapshot
    setCur(12, 34, 56);
    press(1, 0, 0, 0, 0);
    press(1, 0, 0, 0, 0);
    checkOutput("t6_in_min", edit_field, 2'd2);
    s0 = time_strobes; a0 = alarm_strobes;
    doReset();
    idle(3);
    checkOutput("t6_no_pulse", 32'(time_strobes - s0 + alarm_strobes - a0), 32'd0);
    setCur(30, 75, 99);
    press(1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0);
    checkOutput("t6_sanitised", {out_hour, out_min, out_sec}, {8'd1, 8'd0, 8'd0});

    // Random button traffic against the model
    r_mode = 0; r_inc = 0; r_dec = 0; r_conf = 0; r_cancel = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
        r_mode = 0; r_inc = 0; r_dec = 0; r_conf = 0; r_cancel = 0;
      end else if ($urandom_range(0, 149) == 0) begin
        idle(35);
        r_mode = 0; r_inc = 0; r_dec = 0; r_conf = 0; r_cancel = 0;
      end else begin
        if ($urandom_range(0, 7) == 0)
          setCur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        target_sel = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 20) r_mode   = !r_mode;
        if ($urandom_range(0, 99) < 25) r_inc    = !r_inc;
        if ($urandom_range(0, 99) < 25) r_dec    = !r_dec;
        if ($urandom_range(0, 99) < 6)  r_conf   = !r_conf;
        if ($urandom_range(0, 99) < 4)  r_cancel = !r_cancel;
        applyStimulus(r_mode, r_inc, r_dec, r_conf, r_cancel);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
